// File: rtl/video_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants and counter/output types for the video timing generator.
package video_timing_pkg;

  localparam int VGA_CLK_DIV    = 4;
  localparam int VGA_H_VIS      = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_H_TOTAL    = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_VIS      = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;
  localparam int VGA_V_TOTAL    = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_IRQ_STRIDE = 64;

  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;
  typedef logic [8:0] row_t;
  typedef logic [9:0] col_t;
  typedef logic [3:0] overrun_t;
  typedef logic [7:0] frame_t;

  // Half-open window test used for the sync pulse decode.
  function automatic logic in_window(input logic [9:0] v, input int unsigned lo,
                                     input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing/IRQ bundle between the timing generator (master) and the pixel pipeline/CPU (slave).
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic     irq_ack;
  logic     pix_en;
  logic     HS;
  logic     VS;
  logic     blank_N;
  row_t     row;
  col_t     col;
  logic     irq;
  overrun_t irq_overrun;
  frame_t   frame_cnt;

  modport master (input irq_ack,
                  output pix_en, HS, VS, blank_N, row, col, irq, irq_overrun, frame_cnt);
  modport slave  (output irq_ack,
                  input pix_en, HS, VS, blank_N, row, col, irq, irq_overrun, frame_cnt);
endinterface

// File: rtl/video_timing_gen_pix_clk_div.sv
// Divides the system clock down to a one-cycle pixel strobe, high on the last count of each period.
module pix_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  assign div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_en <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// VGA raster timing: pixel/line counters, registered sync/blank/row/col decode, scanline IRQ, frame count.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV    = VGA_CLK_DIV,
  parameter int H_VIS      = VGA_H_VIS,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VIS      = VGA_V_VIS,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int IRQ_STRIDE = VGA_IRQ_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  video_timing_gen_if.master vt
);

  localparam int    H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int    V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int    HS_START = H_VIS + H_FP;
  localparam int    VS_START = V_VIS + V_FP;
  localparam hcnt_t H_LAST   = hcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_LAST   = vcnt_t'(V_TOTAL - 1);

  logic  pix_en;
  hcnt_t hcnt, hcnt_nxt;
  vcnt_t vcnt, vcnt_nxt;
  logic  line_wrap, frame_wrap, irq_event, visible_nxt;

  pix_clk_div #(.CLK_DIV(CLK_DIV)) u_pix_clk_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  assign vt.pix_en = pix_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hcnt_nxt   = hcnt;
    vcnt_nxt   = vcnt;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt_nxt  = '0;
        line_wrap = 1'b1;
        if (vcnt == V_LAST) begin
          vcnt_nxt   = '0;
          frame_wrap = 1'b1;
        end else begin
          vcnt_nxt = vcnt + vcnt_t'(1);
        end
      end else begin
        hcnt_nxt = hcnt + hcnt_t'(1);
      end
    end
    irq_event   = line_wrap && ((32'(vcnt_nxt) % 32'(IRQ_STRIDE)) == 32'd0);
    visible_nxt = (32'(hcnt_nxt) < 32'(H_VIS)) && (32'(vcnt_nxt) < 32'(V_VIS));
  end

  // Outputs decode the next counter values so they land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt           <= '0;
      vcnt           <= '0;
      vt.HS          <= 1'b1;
      vt.VS          <= 1'b1;
      vt.blank_N     <= 1'b1;
      vt.row         <= '0;
      vt.col         <= '0;
      vt.irq         <= 1'b0;
      vt.irq_overrun <= '0;
      vt.frame_cnt   <= '0;
    end else begin
      hcnt       <= hcnt_nxt;
      vcnt       <= vcnt_nxt;
      vt.HS      <= !in_window(hcnt_nxt, HS_START, HS_START + H_SYNC);
      vt.VS      <= !in_window(vcnt_nxt, VS_START, VS_START + V_SYNC);
      vt.blank_N <= visible_nxt;
      vt.row     <= visible_nxt ? vcnt_nxt[8:0] : '0;
      vt.col     <= visible_nxt ? hcnt_nxt : '0;
      if (frame_wrap) vt.frame_cnt <= vt.frame_cnt + frame_t'(1);

      // A new line event beats a simultaneous ack; an ack that coincides is not an overrun.
      if (irq_event) begin
        if (vt.irq && !vt.irq_ack && (vt.irq_overrun != '1))
          vt.irq_overrun <= vt.irq_overrun + overrun_t'(1);
        vt.irq <= 1'b1;
      end else if (vt.irq_ack) begin
        vt.irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: full-size VGA instance for divider/line timing, scaled instance for frame/IRQ behaviour.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  video_timing_gen_if fu ();
  video_timing_gen_if sm ();

  video_timing_gen u_full (.clk(clk), .rst(rst), .vt(fu.master));

  // Scaled raster: 25 px/line (HS px 18..21), 33 lines/frame (VS lines 26..27), IRQ every 4 lines.
  // Line = 100 clk, frame = 3300 clk, 9 IRQ events per frame like the full-size raster.
  video_timing_gen #(
    .CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(5), .IRQ_STRIDE(4)
  ) u_small (.clk(clk), .rst(rst), .vt(sm.master));

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  // Leaves the bench in cycle 0: the cycle right after the last reset edge.
  task automatic do_reset();
    rst        = 1'b1;
    sm.irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({fu.HS, fu.VS, fu.blank_N, fu.pix_en, fu.irq} !== 5'b11100)
      $display("FAIL rst_full_flags: got %b want 11100", {fu.HS, fu.VS, fu.blank_N, fu.pix_en, fu.irq}); else n_pass++;
    n_total++; if ({fu.row, fu.col, fu.irq_overrun, fu.frame_cnt} !== 31'd0)
      $display("FAIL rst_full_vals: row=%0d col=%0d ovr=%0d frame=%0d want all 0", fu.row, fu.col, fu.irq_overrun, fu.frame_cnt); else n_pass++;
    n_total++; if ({sm.HS, sm.VS, sm.blank_N, sm.pix_en, sm.irq} !== 5'b11100)
      $display("FAIL rst_small_flags: got %b want 11100", {sm.HS, sm.VS, sm.blank_N, sm.pix_en, sm.irq}); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++; if (fu.pix_en !== ((cyc % 4) == 3))
        $display("FAIL pix_en_cadence: cycle %0d got %b want %b", cyc, fu.pix_en, ((cyc % 4) == 3)); else n_pass++;
      if (cyc == 3) begin
        n_total++; if (fu.col !== 10'd0) $display("FAIL col_c3: got %0d want 0", fu.col); else n_pass++;
      end
      if (cyc == 4) begin
        n_total++; if (fu.col !== 10'd1) $display("FAIL col_c4: got %0d want 1", fu.col); else n_pass++;
      end
      step();
    end
  endtask

  // Continues from test_reset on the full-size instance through the end of line 0.
  task automatic test_line();
    int hs_first = -1, hs_cnt = 0, bl_first = -1, bl_cnt = 0;
    while (cyc < 3200) begin
      if (!fu.HS) begin
        if (hs_first < 0) hs_first = cyc;
        hs_cnt++;
      end
      if (!fu.blank_N) begin
        if (bl_first < 0) bl_first = cyc;
        bl_cnt++;
      end
      if (cyc == 2559) begin
        n_total++; if ({fu.blank_N, fu.row, fu.col} !== {1'b1, 9'd0, 10'd639})
          $display("FAIL last_visible: blank_N=%b row=%0d col=%0d want 1/0/639", fu.blank_N, fu.row, fu.col); else n_pass++;
      end
      if (cyc == 2560) begin
        n_total++; if ({fu.blank_N, fu.col} !== {1'b0, 10'd0})
          $display("FAIL first_blank: blank_N=%b col=%0d want 0/0", fu.blank_N, fu.col); else n_pass++;
      end
      step();
    end
    n_total++; if (hs_first !== 2624) $display("FAIL hs_start: got %0d want 2624", hs_first); else n_pass++;
    n_total++; if (hs_cnt !== 384) $display("FAIL hs_width: got %0d want 384", hs_cnt); else n_pass++;
    n_total++; if (bl_first !== 2560) $display("FAIL blank_start: got %0d want 2560", bl_first); else n_pass++;
    n_total++; if (bl_cnt !== 640) $display("FAIL blank_width: got %0d want 640", bl_cnt); else n_pass++;
    n_total++; if ({fu.HS, fu.blank_N, fu.row, fu.col} !== {1'b1, 1'b1, 9'd1, 10'd0})
      $display("FAIL line1_start: HS=%b blank_N=%b row=%0d col=%0d want 1/1/1/0", fu.HS, fu.blank_N, fu.row, fu.col); else n_pass++;
  endtask

  task automatic test_frame();
    int   ev = 0, ack_at = -1, vs_cnt = 0, vs_bad = 0, vline;
    logic prev_irq = 1'b0;
    do_reset();
    while (cyc <= 3305) begin
      if (sm.irq && !prev_irq) begin
        ev++;
        ack_at = cyc + 3;
      end
      prev_irq = sm.irq;
      vline = (cyc / 100) % 33;
      if (sm.VS !== !(vline == 26 || vline == 27)) vs_bad++;
      if (!sm.VS) vs_cnt++;
      if (cyc == 3299) begin
        n_total++; if (sm.frame_cnt !== 8'd0) $display("FAIL frame_pre: got %0d want 0", sm.frame_cnt); else n_pass++;
      end
      if (cyc == 3300) begin
        n_total++; if (sm.frame_cnt !== 8'd1) $display("FAIL frame_post: got %0d want 1", sm.frame_cnt); else n_pass++;
      end
      sm.irq_ack = (cyc == ack_at);
      step();
    end
    sm.irq_ack = 1'b0;
    n_total++; if (ev !== 9) $display("FAIL irq_events: got %0d want 9", ev); else n_pass++;
    n_total++; if (vs_cnt !== 200) $display("FAIL vs_width: got %0d want 200", vs_cnt); else n_pass++;
    n_total++; if (vs_bad !== 0) $display("FAIL vs_lines: %0d cycles off, want 0", vs_bad); else n_pass++;
    n_total++; if ({sm.irq, sm.irq_overrun} !== 5'd0)
      $display("FAIL acked_irq: irq=%b ovr=%0d want 0/0", sm.irq, sm.irq_overrun); else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    while (cyc <= 6600) begin
      case (cyc)
        399:  begin n_total++; if (sm.irq !== 1'b0) $display("FAIL ovr_pre_irq: got %b want 0", sm.irq); else n_pass++; end
        400:  begin n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b1, 4'd0}) $display("FAIL ovr_first: irq=%b ovr=%0d want 1/0", sm.irq, sm.irq_overrun); else n_pass++; end
        800:  begin n_total++; if (sm.irq_overrun !== 4'd1) $display("FAIL ovr_800: got %0d want 1", sm.irq_overrun); else n_pass++; end
        3299: begin n_total++; if (sm.irq_overrun !== 4'd7) $display("FAIL ovr_3299: got %0d want 7", sm.irq_overrun); else n_pass++; end
        3300: begin n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b1, 4'd8}) $display("FAIL ovr_frame1: irq=%b ovr=%0d want 1/8", sm.irq, sm.irq_overrun); else n_pass++; end
        5700: begin n_total++; if (sm.irq_overrun !== 4'd14) $display("FAIL ovr_5700: got %0d want 14", sm.irq_overrun); else n_pass++; end
        6100: begin n_total++; if (sm.irq_overrun !== 4'd15) $display("FAIL ovr_6100: got %0d want 15", sm.irq_overrun); else n_pass++; end
        6600: begin n_total++; if ({sm.irq, sm.irq_overrun, sm.frame_cnt} !== {1'b1, 4'd15, 8'd2})
                $display("FAIL ovr_sat: irq=%b ovr=%0d frame=%0d want 1/15/2", sm.irq, sm.irq_overrun, sm.frame_cnt); else n_pass++; end
        default: ;
      endcase
      step();
    end
  endtask

  task automatic test_ack_collision();
    do_reset();
    step_to(399);
    sm.irq_ack = 1'b1;
    step();
    sm.irq_ack = 1'b0;
    n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b1, 4'd0})
      $display("FAIL coll_idle: irq=%b ovr=%0d want 1/0", sm.irq, sm.irq_overrun); else n_pass++;
    step_to(799);
    sm.irq_ack = 1'b1;
    step();
    n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b1, 4'd0})
      $display("FAIL coll_set: irq=%b ovr=%0d want 1/0", sm.irq, sm.irq_overrun); else n_pass++;
    step();
    sm.irq_ack = 1'b0;
    n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b0, 4'd0})
      $display("FAIL ack_late: irq=%b ovr=%0d want 0/0", sm.irq, sm.irq_overrun); else n_pass++;
    step_to(1200);
    n_total++; if ({sm.irq, sm.irq_overrun} !== {1'b1, 4'd0})
      $display("FAIL rearm: irq=%b ovr=%0d want 1/0", sm.irq, sm.irq_overrun); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    step_to(5340);
    n_total++; if ({sm.blank_N, sm.row, sm.col} !== {1'b1, 9'd20, 10'd10})
      $display("FAIL pre_rst_pos: blank_N=%b row=%0d col=%0d want 1/20/10", sm.blank_N, sm.row, sm.col); else n_pass++;
    n_total++; if ({sm.irq, sm.irq_overrun, sm.frame_cnt} !== {1'b1, 4'd13, 8'd1})
      $display("FAIL pre_rst_irq: irq=%b ovr=%0d frame=%0d want 1/13/1", sm.irq, sm.irq_overrun, sm.frame_cnt); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    n_total++; if ({sm.HS, sm.VS, sm.blank_N, sm.pix_en, sm.irq} !== 5'b11100)
      $display("FAIL mid_rst_flags: got %b want 11100", {sm.HS, sm.VS, sm.blank_N, sm.pix_en, sm.irq}); else n_pass++;
    n_total++; if ({sm.row, sm.col, sm.irq_overrun, sm.frame_cnt} !== 31'd0)
      $display("FAIL mid_rst_vals: row=%0d col=%0d ovr=%0d frame=%0d want all 0", sm.row, sm.col, sm.irq_overrun, sm.frame_cnt); else n_pass++;
    step_to(2);
    n_total++; if (sm.pix_en !== 1'b0) $display("FAIL restart_c2: pix_en=%b want 0", sm.pix_en); else n_pass++;
    step_to(3);
    n_total++; if (sm.pix_en !== 1'b1) $display("FAIL restart_c3: pix_en=%b want 1", sm.pix_en); else n_pass++;
    step_to(4);
    n_total++; if ({sm.row, sm.col} !== {9'd0, 10'd1})
      $display("FAIL restart_c4: row=%0d col=%0d want 0/1", sm.row, sm.col); else n_pass++;
  endtask

  initial begin
    fu.irq_ack = 1'b0;
    sm.irq_ack = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_overrun();
    test_ack_collision();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
